// File: rtl/diffeq_pkg.sv
// Shared types for the iterative differential-equation scheduler.
package diffeq_pkg;

   localparam int DataWDef = 32;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_CHK,
      ST_S1,
      ST_S2,
      ST_S3,
      ST_S4,
      ST_S5,
      ST_S6,
      ST_DONE
   } state_t;

   // Multiplier operand pairs, one per scheduled product.
   typedef enum logic [2:0] {
      MUL_U_DX,
      MUL_TH_X,
      MUL_TH_Y,
      MUL_T1_T2,
      MUL_DX_T3
   } mul_sel_t;

   // ALU operand pairs, one per scheduled add/sub/compare.
   typedef enum logic [2:0] {
      SRC_X_A,
      SRC_X_DX,
      SRC_Y_T1,
      SRC_XN_A,
      SRC_U_T4,
      SRC_T6_T5
   } alu_src_t;

   typedef enum logic [1:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_LT
   } alu_op_t;

endpackage

// File: rtl/diffeq_alu.sv
// Shared add / subtract / signed-less-than unit. LT returns 0 or 1 in bit 0.
module diffeq_alu
   import diffeq_pkg::*;
#(
   parameter int W = DataWDef
) (
   input  alu_op_t        op,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic [W-1:0]   y
);

   // Single combinational operation selected by op; sums wrap modulo 2^W.
   always_comb begin
      y = '0;
      case (op)
         ALU_ADD: y = a + b;
         ALU_SUB: y = a - b;
         ALU_LT:  y = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
         default: y = '0;
      endcase
   end

endmodule

// File: rtl/diffeq_sched_ctrl.sv
// Iterative while (x < a) solver: one multiplier and one ALU shared under a
// fixed 6-cycle schedule per iteration.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for Start; inputs captured on acceptance
// CHK     | initial loop test x < a (zero-trip goes straight to DONE)
// S1      | t1 = u*dx,   xn = x + dx
// S2      | t2 = 3*x,    yn = y + t1
// S3      | t3 = 3*y,    cn = xn < a
// S4      | t4 = t1*t2
// S5      | t5 = dx*t3,  t6 = u - t4
// S6      | u = t6 - t5, commit x, y, iteration count; loop or finish
// DONE    | one-cycle Done pulse, results already visible
module diffeq_sched_ctrl
   import diffeq_pkg::*;
#(
   parameter int DataW   = DataWDef,
   parameter int IterW   = 16,
   parameter int MaxIter = 1000
) (
   input  logic               Clk,
   input  logic               Rst,
   input  logic               Start,
   input  logic [DataW-1:0]   u,
   input  logic [DataW-1:0]   x,
   input  logic [DataW-1:0]   y,
   input  logic [DataW-1:0]   dx,
   input  logic [DataW-1:0]   a,
   input  logic [DataW-1:0]   three,
   output logic [DataW-1:0]   u1,
   output logic [DataW-1:0]   x1,
   output logic [DataW-1:0]   y1,
   output logic               c,
   output logic [IterW-1:0]   Iter,
   output logic               Ovf,
   output logic               Busy,
   output logic               Done
);

   state_t             state, state_nxt;
   mul_sel_t           mul_sel;
   alu_src_t           alu_src;
   alu_op_t            alu_op;
   logic               fin;

   logic [DataW-1:0]   uw, xw, yw, dxr, ar, thr;
   logic [DataW-1:0]   t1, t2, t3, t4, t5, t6, xn, yn;
   logic               cn;
   logic [IterW-1:0]   iter_cnt, iter_inc;

   logic [DataW-1:0]   mul_a, mul_b, mul_res;
   logic [DataW-1:0]   alu_a, alu_b, alu_res;

   assign iter_inc = iter_cnt + 1'b1;
   assign Busy     = (state != ST_IDLE);
   assign Done     = (state == ST_DONE);

   // State register.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) state <= ST_IDLE;
      else      state <= state_nxt;
   end

   // Per-state operand selects for the shared multiplier and ALU.
   always_comb begin
      mul_sel = MUL_U_DX;
      alu_src = SRC_X_A;
      alu_op  = ALU_LT;
      case (state)
         ST_CHK: begin alu_src = SRC_X_A;   alu_op = ALU_LT;  end
         ST_S1:  begin mul_sel = MUL_U_DX;  alu_src = SRC_X_DX;  alu_op = ALU_ADD; end
         ST_S2:  begin mul_sel = MUL_TH_X;  alu_src = SRC_Y_T1;  alu_op = ALU_ADD; end
         ST_S3:  begin mul_sel = MUL_TH_Y;  alu_src = SRC_XN_A;  alu_op = ALU_LT;  end
         ST_S4:  begin mul_sel = MUL_T1_T2; end
         ST_S5:  begin mul_sel = MUL_DX_T3; alu_src = SRC_U_T4;  alu_op = ALU_SUB; end
         ST_S6:  begin alu_src = SRC_T6_T5; alu_op = ALU_SUB; end
         default: ;
      endcase
   end

   // Next state; fin marks the transition into DONE where results are loaded.
   always_comb begin
      state_nxt = state;
      fin       = 1'b0;
      case (state)
         ST_IDLE: if (Start) state_nxt = ST_CHK;
         ST_CHK: begin
            if (alu_res[0]) state_nxt = ST_S1;
            else begin
               state_nxt = ST_DONE;
               fin       = 1'b1;
            end
         end
         ST_S1:   state_nxt = ST_S2;
         ST_S2:   state_nxt = ST_S3;
         ST_S3:   state_nxt = ST_S4;
         ST_S4:   state_nxt = ST_S5;
         ST_S5:   state_nxt = ST_S6;
         ST_S6: begin
            if (cn && (iter_inc < IterW'(MaxIter))) state_nxt = ST_S1;
            else begin
               state_nxt = ST_DONE;
               fin       = 1'b1;
            end
         end
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Operand muxes in front of the shared units.
   always_comb begin
      mul_a = uw;
      mul_b = dxr;
      case (mul_sel)
         MUL_U_DX:  begin mul_a = uw;  mul_b = dxr; end
         MUL_TH_X:  begin mul_a = thr; mul_b = xw;  end
         MUL_TH_Y:  begin mul_a = thr; mul_b = yw;  end
         MUL_T1_T2: begin mul_a = t1;  mul_b = t2;  end
         MUL_DX_T3: begin mul_a = dxr; mul_b = t3;  end
         default:   ;
      endcase
      alu_a = xw;
      alu_b = ar;
      case (alu_src)
         SRC_X_A:   begin alu_a = xw; alu_b = ar;  end
         SRC_X_DX:  begin alu_a = xw; alu_b = dxr; end
         SRC_Y_T1:  begin alu_a = yw; alu_b = t1;  end
         SRC_XN_A:  begin alu_a = xn; alu_b = ar;  end
         SRC_U_T4:  begin alu_a = uw; alu_b = t4;  end
         SRC_T6_T5: begin alu_a = t6; alu_b = t5;  end
         default:   ;
      endcase
   end

   // Low DataW bits of the product are identical for signed and unsigned.
   assign mul_res = mul_a * mul_b;

   diffeq_alu #(.W(DataW)) u_alu (
      .op (alu_op),
      .a  (alu_a),
      .b  (alu_b),
      .y  (alu_res)
   );

   // Working registers, scheduled intermediates and held results.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         uw <= '0; xw <= '0; yw <= '0; dxr <= '0; ar <= '0; thr <= '0;
         t1 <= '0; t2 <= '0; t3 <= '0; t4 <= '0; t5 <= '0; t6 <= '0;
         xn <= '0; yn <= '0; cn <= 1'b0; iter_cnt <= '0;
         u1 <= '0; x1 <= '0; y1 <= '0; c <= 1'b0; Iter <= '0; Ovf <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: if (Start) begin
               uw <= u; xw <= x; yw <= y; dxr <= dx; ar <= a; thr <= three;
               iter_cnt <= '0;
            end
            ST_S1: begin t1 <= mul_res; xn <= alu_res; end
            ST_S2: begin t2 <= mul_res; yn <= alu_res; end
            ST_S3: begin t3 <= mul_res; cn <= alu_res[0]; end
            ST_S4: t4 <= mul_res;
            ST_S5: begin t5 <= mul_res; t6 <= alu_res; end
            ST_S6: begin
               uw <= alu_res; xw <= xn; yw <= yn;
               iter_cnt <= iter_inc;
            end
            default: ;
         endcase
         if (fin) begin
            if (state == ST_S6) begin
               u1 <= alu_res; x1 <= xn; y1 <= yn;
               c <= cn; Iter <= iter_inc; Ovf <= cn;
            end else begin
               u1 <= uw; x1 <= xw; y1 <= yw;
               c <= 1'b0; Iter <= iter_cnt; Ovf <= 1'b0;
            end
         end
      end
   end

endmodule
